// File: rtl/id_stage_fwd_n_pkg.sv
// Shared decode constants for the ID stage: opcodes, branch funct3 codes,
// the canonical NOP and the immediate-format classifier.
package id_pkg;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Immediate layout implied by the major opcode
  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: return IMM_I;
      OP_STORE:                            return IMM_S;
      OP_BRANCH:                           return IMM_B;
      OP_AUIPC, OP_LUI:                    return IMM_U;
      OP_JAL:                              return IMM_J;
      default:                             return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_fwd_n_if.sv
// Fetch-to-decode handshake: IF presents {PC, instruction, valid},
// ID answers with its ready flag.
interface id_stage_fwd_n_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] PC_IF;
  logic [31:0]     inst_IF;
  logic            valid_IF;
  logic            ready_ID;

  modport master (output PC_IF, output inst_IF, output valid_IF, input ready_ID);
  modport slave  (input PC_IF, input inst_IF, input valid_IF, output ready_ID);
endinterface

// File: rtl/id_stage_fwd_n_regfile.sv
// Architectural register file: x0 hardwired to zero, synchronous write,
// combinational read with write-through so a same-cycle write is visible.
module id_regfile #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [RA_W-1:0] i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [RA_W-1:0] i_raddr1,
  input  logic [RA_W-1:0] i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_mem [0:(2**RA_W)-1];

  // Write port; entry 0 is never written so it stays at its reset value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2**RA_W; k++) r_mem[k] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port 1 with x0 forcing and write-through bypass
  always_comb begin
    o_rdata1 = r_mem[i_raddr1];
    if (i_raddr1 == '0)                         o_rdata1 = '0;
    else if (i_we && (i_waddr == i_raddr1))     o_rdata1 = i_wdata;
  end

  // Read port 2 with x0 forcing and write-through bypass
  always_comb begin
    o_rdata2 = r_mem[i_raddr2];
    if (i_raddr2 == '0)                         o_rdata2 = '0;
    else if (i_we && (i_waddr == i_raddr2))     o_rdata2 = i_wdata;
  end

endmodule

// File: rtl/id_stage_fwd_n.sv
// Decode stage: IF/ID register, register fetch, N-source operand
// forwarding with readiness-based hazard stall, and branch/jump resolution.
module id_stage_fwd_n #(
  parameter int XLEN  = 32,
  parameter int N_FWD = 3,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  id_stage_fwd_n_if.slave        fetch,
  input  logic                   stall_ext,
  input  logic [RA_W*N_FWD-1:0]  rdAddr_out,
  input  logic [N_FWD-1:0]       regWrite_out,
  input  logic [XLEN*N_FWD-1:0]  DATA_out,
  input  logic [N_FWD-1:0]       ready_out,
  input  logic                   regWrite_WB,
  input  logic [RA_W-1:0]        rdAddr_WB,
  input  logic [XLEN-1:0]        rdData_WB,
  output logic [XLEN-1:0]        PC_ID,
  output logic [31:0]            inst_ID,
  output logic                   valid_ID,
  output logic [RA_W-1:0]        rs1Addr_ID,
  output logic [RA_W-1:0]        rs2Addr_ID,
  output logic [RA_W-1:0]        rdAddr_ID,
  output logic [XLEN-1:0]        rs1Data_ID,
  output logic [XLEN-1:0]        rs2Data_ID,
  output logic [XLEN-1:0]        imm_ID,
  output logic [XLEN-1:0]        jump_addr,
  output logic                   redirect,
  output logic                   stall,
  output logic                   reg_DE_flush,
  output logic                   ready_ID,
  output logic [CNT_W-1:0]       perf_stall_cnt
);
  import id_pkg::*;

  typedef struct packed {
    logic            hit;
    logic            rdy;
    logic [XLEN-1:0] data;
  } fwd_t;

  // Youngest-first source select; an older stage never masks a younger one
  function automatic fwd_t fwd_pick(input logic [RA_W-1:0]       rs,
                                    input logic [N_FWD-1:0]      we,
                                    input logic [RA_W*N_FWD-1:0] rd,
                                    input logic [XLEN*N_FWD-1:0] dat,
                                    input logic [N_FWD-1:0]      rdy);
    fwd_t f;
    f = '{hit: 1'b0, rdy: 1'b1, data: '0};
    for (int i = N_FWD - 1; i >= 0; i--) begin
      if (we[i] && (rd[i*RA_W +: RA_W] == rs) && (rs != '0)) begin
        f.hit  = 1'b1;
        f.rdy  = rdy[i];
        f.data = dat[i*XLEN +: XLEN];
      end
    end
    return f;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [XLEN-1:0]   r_pc_p1;
  logic [31:0]       r_inst_p1;
  logic              r_vld_p1;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [6:0]        w_op;
  logic [2:0]        w_f3;
  logic [RA_W-1:0]   w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0]   w_rf1, w_rf2;
  fwd_t              w_f1, w_f2;
  logic [XLEN-1:0]   w_op1, w_op2;
  logic signed [XLEN-1:0] w_op1_s, w_op2_s;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]   w_imm;
  logic              w_taken, w_is_jal, w_is_jalr, w_is_br;
  logic              w_stall, w_redirect;
  logic [XLEN-1:0]   w_jalr_sum;
  logic [XLEN-1:0]   w_target;

  assign w_op = r_inst_p1[6:0];
  assign w_f3 = r_inst_p1[14:12];

  // Register fields, masked per opcode and cleared for an empty slot
  always_comb begin
    w_rs1 = RA_W'(r_inst_p1[19:15]);
    w_rs2 = RA_W'(r_inst_p1[24:20]);
    w_rd  = RA_W'(r_inst_p1[11:7]);
    if (!r_vld_p1 || w_op == OP_STORE || w_op == OP_BRANCH) w_rd = '0;
    if (!r_vld_p1 || w_op == OP_AUIPC || w_op == OP_LUI || w_op == OP_JAL) w_rs1 = '0;
    if (!r_vld_p1 || w_op == OP_LOAD || w_op == OP_IMM || w_op == OP_AUIPC ||
        w_op == OP_LUI || w_op == OP_JALR || w_op == OP_JAL || w_op == OP_SYSTEM) w_rs2 = '0;
  end

  id_regfile #(.XLEN(XLEN), .RA_W(RA_W)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .i_we     (regWrite_WB),
    .i_waddr  (rdAddr_WB),
    .i_wdata  (rdData_WB),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rf1),
    .o_rdata2 (w_rf2)
  );

  assign w_f1  = fwd_pick(w_rs1, regWrite_out, rdAddr_out, DATA_out, ready_out);
  assign w_f2  = fwd_pick(w_rs2, regWrite_out, rdAddr_out, DATA_out, ready_out);
  assign w_op1 = w_f1.hit ? w_f1.data : w_rf1;
  assign w_op2 = w_f2.hit ? w_f2.data : w_rf2;
  assign w_op1_s = w_op1;
  assign w_op2_s = w_op2;

  assign w_stall = r_vld_p1 & ((w_f1.hit & ~w_f1.rdy) | (w_f2.hit & ~w_f2.rdy));

  // Immediate assembly; sign comes from inst[31] for every format
  always_comb begin
    w_imm32 = '0;
    case (imm_fmt(w_op))
      IMM_I: w_imm32 = {{20{r_inst_p1[31]}}, r_inst_p1[31:20]};
      IMM_S: w_imm32 = {{20{r_inst_p1[31]}}, r_inst_p1[31:25], r_inst_p1[11:7]};
      IMM_B: w_imm32 = {{19{r_inst_p1[31]}}, r_inst_p1[31], r_inst_p1[7],
                        r_inst_p1[30:25], r_inst_p1[11:8], 1'b0};
      IMM_U: w_imm32 = {r_inst_p1[31:12], 12'b0};
      IMM_J: w_imm32 = {{11{r_inst_p1[31]}}, r_inst_p1[31], r_inst_p1[19:12],
                        r_inst_p1[20], r_inst_p1[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign w_imm = r_vld_p1 ? XLEN'(w_imm32) : '0;

  // Branch condition on the forwarded operands
  always_comb begin
    case (w_f3)
      F3_BEQ:  w_taken = (w_op1 == w_op2);
      F3_BNE:  w_taken = (w_op1 != w_op2);
      F3_BLT:  w_taken = (w_op1_s <  w_op2_s);
      F3_BGE:  w_taken = (w_op1_s >= w_op2_s);
      F3_BLTU: w_taken = (w_op1 <  w_op2);
      F3_BGEU: w_taken = (w_op1 >= w_op2);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_is_jal  = r_vld_p1 & (w_op == OP_JAL);
  assign w_is_jalr = r_vld_p1 & (w_op == OP_JALR);
  assign w_is_br   = r_vld_p1 & (w_op == OP_BRANCH);

  // Target selection; JALR clears bit 0 of the register-relative sum
  always_comb begin
    w_jalr_sum    = w_op1 + w_imm;
    w_jalr_sum[0] = 1'b0;
    w_target      = '0;
    if (w_is_jalr)                 w_target = w_jalr_sum;
    else if (w_is_jal || w_is_br)  w_target = r_pc_p1 + w_imm;
  end

  assign w_redirect = r_vld_p1 & ~w_stall & ~stall_ext &
                      (w_is_jal | w_is_jalr | (w_is_br & w_taken));

  // IF/ID register: hold on any stall, squash behind a redirect, else load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_p1   <= '0;
      r_inst_p1 <= NOP_INST;
      r_vld_p1  <= 1'b0;
    end else if (!(w_stall || stall_ext)) begin
      if (w_redirect) begin
        r_inst_p1 <= NOP_INST;
        r_vld_p1  <= 1'b0;
      end else begin
        r_pc_p1   <= fetch.PC_IF;
        r_inst_p1 <= fetch.inst_IF;
        r_vld_p1  <= fetch.valid_IF;
      end
    end
  end

  // Saturating count of data-hazard stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_stall_cnt <= '0;
    else if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
  end

  assign PC_ID          = r_pc_p1;
  assign inst_ID        = r_inst_p1;
  assign valid_ID       = r_vld_p1;
  assign rs1Addr_ID     = w_rs1;
  assign rs2Addr_ID     = w_rs2;
  assign rdAddr_ID      = w_rd;
  assign rs1Data_ID     = r_vld_p1 ? w_op1 : '0;
  assign rs2Data_ID     = r_vld_p1 ? w_op2 : '0;
  assign imm_ID         = w_imm;
  assign jump_addr      = w_target;
  assign redirect       = w_redirect;
  assign stall          = w_stall;
  assign reg_DE_flush   = w_stall & ~stall_ext;
  assign ready_ID       = ~(w_stall | stall_ext);
  assign fetch.ready_ID = ready_ID;
  assign perf_stall_cnt = r_stall_cnt;

endmodule
